mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers; the sequential companion to the datapath ALU in the EX stage of the pipelined MIPS core.
- Accepts signed/unsigned mult/div, models a fixed latency with a busy counter, and commits results to HI/LO at completion.
- Also services mthi/mtlo writes and mfhi/mflo reads.
- The hazard unit stalls any MDU-class instruction while busy=1 or start=1.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_LAT, 5, cycles busy is held for mult/multu (>=1).
- DIV_LAT, 10, cycles busy is held for div/divu (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  qualifies op for one cycle; ignored while busy=1.
- op  input  4  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, NONE.
- src_a  input  WIDTH  rs operand / dividend.
- src_b  input  WIDTH  rt operand / divisor.
- busy  output  1  registered; high while an operation is in flight.
- hi  output  WIDTH  registered HI.
- lo  output  WIDTH  registered LO.
- rd_data  output  WIDTH  combinational: lo when op==MFLO, else hi.

Behaviour:
- Reset (reset_n low, asynchronous): busy=0, hi=0, lo=0, counter=0, latched operands/op cleared. A reset mid-operation aborts it, and no commit follows.
- Accept on the edge where start=1 and busy=0:
  - MULT/MULTU/DIV/DIVU: latch src_a, src_b and op. Load the counter with MUL_LAT or DIV_LAT. busy=1 from the next cycle.
  - MTHI: hi<=src_a at that edge. MTLO: lo<=src_a at that edge. busy stays 0.
  - MFHI, MFLO, NONE: no state change.
- Counter: decrements each cycle while busy. If accepted at edge T, busy is high for cycles T+1..T+LAT.
- Commit at edge T+LAT: busy falls and HI/LO take results from the latched operands. New values are visible the cycle after the commit edge. A new start may be accepted in that cycle.
- start=1 while busy=1: ignored entirely, including MT ops. No queueing. Stalling is the hazard unit's job.
- MULT: {hi,lo} = signed(a) * signed(b), 2*WIDTH-bit product.
- MULTU: {hi,lo} = unsigned(a) * unsigned(b).
- DIV: lo = quotient, truncated toward zero. hi = remainder, with the sign of the dividend.
- Division special cases:
  - DIV with a = most-negative and b = -1: lo = most-negative, hi = 0, no trap.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (DIV or DIVU): the operation still runs for DIV_LAT cycles, but hi/lo are left unchanged at commit.
- rd_data always reflects committed hi/lo. It is not forwarded from an in-flight operation.
- The source values of a latched op are unaffected by later src_a/src_b changes.

Decomposition:
- Package mdu_pkg holds:
  - op encodings: MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6, MDU_MFHI=7, MDU_MFLO=8;
  - a function is_mdu_busy_op(op).
- One sub-module, mdu_calc: purely combinational. Inputs: latched op, a, b. Outputs: hi_res, lo_res, div_by_zero. It isolates the arithmetic and width rules from the counter/commit control in mdu_unit.

Test Plan:
- MULT with a=-3 (0xFFFFFFFD), b=5: busy high exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU with the same operands: hi=0x00000004, lo=0xFFFFFFF1.
- DIV with a=-7, b=2: busy high 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with a=7, b=2: lo=3, hi=1.
- DIV with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0. DIVU with b=0 after MTHI 0x11/MTLO 0x22: busy 10 cycles, then hi=0x11, lo=0x22 (unchanged).
- MULT accepted; MTHI 0xAAAA and a second MULT asserted with start on busy cycles 2 and 3: both ignored, and the final hi/lo equal the first product only. A start in the cycle right after busy falls is accepted.
- Reset_n pulsed low asynchronously (mid-cycle) during DIV cycle 4: busy, hi and lo read 0 immediately, and there is no commit after reset release.
- MFLO/MFHI select: with hi=0x1234, lo=0x5678, op=MFLO gives rd_data=0x5678 and op=MFHI gives 0x1234 in the same cycle, with no state change.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op encodings and helpers for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  // Ops that occupy the unit for a multi-cycle latency window.
  function automatic logic is_mdu_busy_op(mdu_op_e op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mdu_if #(parameter int WIDTH = 32);
  import mdu_pkg::*;

  logic             start;
  mdu_op_e          op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;

  modport master (output start, op, src_a, src_b, input busy, hi, lo, rd_data);
  modport slave  (input start, op, src_a, src_b, output busy, hi, lo, rd_data);
endinterface

// File: rtl/mdu_calc.sv
// Combinational mult/div arithmetic on the latched operands.
module mdu_calc import mdu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res,
  output logic             div_by_zero
);
  logic               sgn;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   ua, ub, ub_safe, q, r, quo, rem;

  always_comb begin
    sgn   = (op == MDU_MULT) || (op == MDU_DIV);
    // Low 2W bits of a product of sign-extended operands equal the signed product.
    a_ext = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    b_ext = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    prod  = a_ext * b_ext;

    // Magnitude division: most-negative / -1 falls out as 0x80..0 with no overflow.
    a_neg   = sgn && a[WIDTH-1];
    b_neg   = sgn && b[WIDTH-1];
    ua      = a_neg ? -a : a;
    ub      = b_neg ? -b : b;
    ub_safe = (b == '0) ? WIDTH'(1) : ub;
    q       = ua / ub_safe;
    r       = ua % ub_safe;
    quo     = (a_neg ^ b_neg) ? -q : q;
    rem     = a_neg ? -r : r;

    div_by_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == '0);
    if ((op == MDU_MULT) || (op == MDU_MULTU)) begin
      hi_res = prod[2*WIDTH-1:WIDTH];
      lo_res = prod[WIDTH-1:0];
    end else begin
      hi_res = rem;
      lo_res = quo;
    end
  end
endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
module mdu_unit import mdu_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic clk,
  input  logic reset_n,
  mdu_if.slave bus
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic             busy_q;
  logic [CW-1:0]    cnt;
  mdu_op_e          op_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic [WIDTH-1:0] hi_res, lo_res;
  logic             dbz;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .hi_res      (hi_res),
    .lo_res      (lo_res),
    .div_by_zero (dbz)
  );

  // Counter loaded with the latency at accept; commit on the edge it leaves 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt    <= '0;
      op_q   <= MDU_NONE;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (busy_q) begin
      if (cnt == CW'(1)) begin
        busy_q <= 1'b0;
        cnt    <= '0;
        if (!dbz) begin
          hi_q <= hi_res;
          lo_q <= lo_res;
        end
      end else begin
        cnt <= cnt - CW'(1);
      end
    end else if (bus.start) begin
      if (is_mdu_busy_op(bus.op)) begin
        a_q    <= bus.src_a;
        b_q    <= bus.src_b;
        op_q   <= bus.op;
        busy_q <= 1'b1;
        cnt    <= (bus.op inside {MDU_MULT, MDU_MULTU}) ? CW'(MUL_LAT) : CW'(DIV_LAT);
      end else if (bus.op == MDU_MTHI) begin
        hi_q <= bus.src_a;
      end else if (bus.op == MDU_MTLO) begin
        lo_q <= bus.src_a;
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.rd_data = (bus.op == MDU_MFLO) ? lo_q : hi_q;
endmodule
